// File: rtl/d_b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : d_b_pipe
// Purpose  : Pipelined piecewise-linear evaluator of the LNS difference
//            function d_b(z) = log2(1 - 2^z), used on the subtraction path
//            of the LNS fused adder beside the s_b(z) unit.
//            Operands and results are signed Q3.7 (128 = 1.0), z <= 0.
//            A valid/ready handshake lets the datapath stall; the whole pipe
//            advances together, so bubbles are never collapsed.
//
// Parameters:
//   PIPE_MUL : 1 = multiply registered in its own stage (latency 3)
//              0 = multiply and add share one stage     (latency 2)
//   TAG_W    : width of the opaque sideband tag carried with each sample
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   input sample valid
//   in_ready     out  block can accept a sample this cycle
//   in_z         in   [10:0] signed Q3.7 operand difference z
//   in_tag       in   [TAG_W-1:0] sideband tag
//   out_valid    out  result valid
//   out_ready    in   downstream accepts the result
//   out_db       out  [10:0] signed Q3.7 d_b(z), range [-1024, 0]
//   out_sing     out  input was z >= 0 (singular / out of domain)
//   out_tag      out  [TAG_W-1:0] tag of this result
//
// Optional feature (macro LNS_DB_SING_CNT_EN):
//   sing_cnt     out  [15:0] saturating count of transferred singular results
//   sing_cnt_clr in   synchronous clear, wins over increment
//
// Revision : 1.0  initial release
// ============================================================================

module d_b_pipe #(
   parameter int PIPE_MUL = 1,
   parameter int TAG_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [10:0]      in_z,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      out_db,
   output logic             out_sing,
   output logic [TAG_W-1:0] out_tag
`ifdef LNS_DB_SING_CNT_EN
   ,
   output logic [15:0]      sing_cnt,
   input  logic             sing_cnt_clr
`endif
);

   // -------------------------------------------------------------------------
   // Segment table
   // -------------------------------------------------------------------------
   // Lower bounds of segments S1..S6 (S0 starts at -1024).
   localparam logic signed [10:0] Z_LO_S1 = -11'sd512;
   localparam logic signed [10:0] Z_LO_S2 = -11'sd256;
   localparam logic signed [10:0] Z_LO_S3 = -11'sd128;
   localparam logic signed [10:0] Z_LO_S4 = -11'sd64;
   localparam logic signed [10:0] Z_LO_S5 = -11'sd32;
   localparam logic signed [10:0] Z_LO_S6 = -11'sd16;

   // Low 10 bits of each segment's z_lo. Every segment spans fewer than 1024
   // codes, so d = z - z_lo is exact when computed modulo 2^10.
   localparam logic [9:0] BASE_S0 = 10'h000;   // -1024
   localparam logic [9:0] BASE_S1 = 10'h200;   // -512
   localparam logic [9:0] BASE_S2 = 10'h300;   // -256
   localparam logic [9:0] BASE_S3 = 10'h380;   // -128
   localparam logic [9:0] BASE_S4 = 10'h3C0;   // -64
   localparam logic [9:0] BASE_S5 = 10'h3E0;   // -32
   localparam logic [9:0] BASE_S6 = 10'h3F0;   // -16

   // d_b at each segment's left end point.
   localparam logic signed [10:0] Y_S0 = -11'sd1;
   localparam logic signed [10:0] Y_S1 = -11'sd12;
   localparam logic signed [10:0] Y_S2 = -11'sd53;
   localparam logic signed [10:0] Y_S3 = -11'sd128;
   localparam logic signed [10:0] Y_S4 = -11'sd227;
   localparam logic signed [10:0] Y_S5 = -11'sd339;
   localparam logic signed [10:0] Y_S6 = -11'sd460;

   // Slopes, scaled by 256 (the product is shifted right by 8).
   localparam logic signed [14:0] K_S0 = -15'sd5;
   localparam logic signed [14:0] K_S1 = -15'sd41;
   localparam logic signed [14:0] K_S2 = -15'sd150;
   localparam logic signed [14:0] K_S3 = -15'sd396;
   localparam logic signed [14:0] K_S4 = -15'sd896;
   localparam logic signed [14:0] K_S5 = -15'sd1936;
   localparam logic signed [14:0] K_S6 = -15'sd8602;

   localparam logic [10:0] DB_SING = 11'h400;  // -1024

   // -------------------------------------------------------------------------
   // Handshake: one shared advance enable for every stage
   // -------------------------------------------------------------------------
   logic out_valid_q, out_valid_d;
   logic adv;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // -------------------------------------------------------------------------
   // Stage 1: segment decode
   // -------------------------------------------------------------------------
   logic signed [10:0] z_s;
   logic        [9:0]  seg_base;
   logic signed [10:0] seg_ylo;
   logic signed [14:0] seg_k;
   logic               seg_sing;

   assign z_s = in_z;

   always_comb begin
      seg_base = BASE_S0;
      seg_ylo  = '0;
      seg_k    = '0;
      seg_sing = 1'b0;
      if (!z_s[10]) begin
         // z >= 0: no table value; stage 3 substitutes the saturated result.
         seg_sing = 1'b1;
      end else if (z_s < Z_LO_S1) begin
         seg_base = BASE_S0; seg_ylo = Y_S0; seg_k = K_S0;
      end else if (z_s < Z_LO_S2) begin
         seg_base = BASE_S1; seg_ylo = Y_S1; seg_k = K_S1;
      end else if (z_s < Z_LO_S3) begin
         seg_base = BASE_S2; seg_ylo = Y_S2; seg_k = K_S2;
      end else if (z_s < Z_LO_S4) begin
         seg_base = BASE_S3; seg_ylo = Y_S3; seg_k = K_S3;
      end else if (z_s < Z_LO_S5) begin
         seg_base = BASE_S4; seg_ylo = Y_S4; seg_k = K_S4;
      end else if (z_s < Z_LO_S6) begin
         seg_base = BASE_S5; seg_ylo = Y_S5; seg_k = K_S5;
      end else begin
         seg_base = BASE_S6; seg_ylo = Y_S6; seg_k = K_S6;
      end
   end

   logic                    s1_valid_q, s1_valid_d;
   logic        [9:0]       s1_d_q,     s1_d_d;
   logic signed [14:0]      s1_k_q,     s1_k_d;
   logic signed [10:0]      s1_ylo_q,   s1_ylo_d;
   logic                    s1_sing_q,  s1_sing_d;
   logic        [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d_d     = s1_d_q;
      s1_k_d     = s1_k_q;
      s1_ylo_d   = s1_ylo_q;
      s1_sing_d  = s1_sing_q;
      s1_tag_d   = s1_tag_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_d_d     = in_z[9:0] - seg_base;
         s1_k_d     = seg_k;
         s1_ylo_d   = seg_ylo;
         s1_sing_d  = seg_sing;
         s1_tag_d   = in_tag;
      end
   end

   // -------------------------------------------------------------------------
   // Multiply: d (unsigned) * k (signed), both widened to 24 bits signed
   // -------------------------------------------------------------------------
   logic signed [23:0] mul_a;
   logic signed [23:0] mul_b;
   logic signed [23:0] mul_p;

   assign mul_a = {14'd0, s1_d_q};
   assign mul_b = {{9{s1_k_q[14]}}, s1_k_q};
   assign mul_p = mul_a * mul_b;

   // Inputs of the final add/saturate stage, sourced per PIPE_MUL.
   logic                    st3_valid;
   logic signed [23:0]      st3_p;
   logic signed [10:0]      st3_ylo;
   logic                    st3_sing;
   logic        [TAG_W-1:0] st3_tag;

   generate
      if (PIPE_MUL != 0) begin : g_mul_reg
         logic                    s2_valid_q, s2_valid_d;
         logic signed [23:0]      s2_p_q,     s2_p_d;
         logic signed [10:0]      s2_ylo_q,   s2_ylo_d;
         logic                    s2_sing_q,  s2_sing_d;
         logic        [TAG_W-1:0] s2_tag_q,   s2_tag_d;

         always_comb begin
            s2_valid_d = s2_valid_q;
            s2_p_d     = s2_p_q;
            s2_ylo_d   = s2_ylo_q;
            s2_sing_d  = s2_sing_q;
            s2_tag_d   = s2_tag_q;
            if (adv) begin
               s2_valid_d = s1_valid_q;
               s2_p_d     = mul_p;
               s2_ylo_d   = s1_ylo_q;
               s2_sing_d  = s1_sing_q;
               s2_tag_d   = s1_tag_q;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_p_q     <= '0;
               s2_ylo_q   <= '0;
               s2_sing_q  <= 1'b0;
               s2_tag_q   <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_p_q     <= s2_p_d;
               s2_ylo_q   <= s2_ylo_d;
               s2_sing_q  <= s2_sing_d;
               s2_tag_q   <= s2_tag_d;
            end
         end

         assign st3_valid = s2_valid_q;
         assign st3_p     = s2_p_q;
         assign st3_ylo   = s2_ylo_q;
         assign st3_sing  = s2_sing_q;
         assign st3_tag   = s2_tag_q;
      end else begin : g_mul_comb
         assign st3_valid = s1_valid_q;
         assign st3_p     = mul_p;
         assign st3_ylo   = s1_ylo_q;
         assign st3_sing  = s1_sing_q;
         assign st3_tag   = s1_tag_q;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Final stage: r = y_lo + floor(p / 256), saturated to [-1024, 0]
   // -------------------------------------------------------------------------
   // Kept as separate signed signals so the shift stays arithmetic.
   logic signed [23:0] ylo_ext;
   logic signed [23:0] p_sh;
   logic signed [23:0] r_wide;
   logic        [10:0] r_sat;

   assign ylo_ext = {{13{st3_ylo[10]}}, st3_ylo};
   assign p_sh    = st3_p >>> 8;
   assign r_wide  = ylo_ext + p_sh;

   always_comb begin
      if (r_wide < -24'sd1024) begin
         r_sat = DB_SING;
      end else if (r_wide > 24'sd0) begin
         r_sat = 11'd0;
      end else begin
         r_sat = r_wide[10:0];
      end
   end

   logic        [10:0]      out_db_q,   out_db_d;
   logic                    out_sing_q, out_sing_d;
   logic        [TAG_W-1:0] out_tag_q,  out_tag_d;

   always_comb begin
      out_valid_d = out_valid_q;
      out_db_d    = out_db_q;
      out_sing_d  = out_sing_q;
      out_tag_d   = out_tag_q;
      if (adv) begin
         out_valid_d = st3_valid;
         out_db_d    = st3_sing ? DB_SING : r_sat;
         out_sing_d  = st3_sing;
         out_tag_d   = st3_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_d_q      <= '0;
         s1_k_q      <= '0;
         s1_ylo_q    <= '0;
         s1_sing_q   <= 1'b0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_db_q    <= '0;
         out_sing_q  <= 1'b0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_d_q      <= s1_d_d;
         s1_k_q      <= s1_k_d;
         s1_ylo_q    <= s1_ylo_d;
         s1_sing_q   <= s1_sing_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_db_q    <= out_db_d;
         out_sing_q  <= out_sing_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_db    = out_db_q;
   assign out_sing  = out_sing_q;
   assign out_tag   = out_tag_q;

`ifdef LNS_DB_SING_CNT_EN
   // -------------------------------------------------------------------------
   // Singular-result counter: counts transferred results with out_sing set
   // -------------------------------------------------------------------------
   logic [15:0] sing_cnt_q, sing_cnt_d;

   always_comb begin
      sing_cnt_d = sing_cnt_q;
      if (sing_cnt_clr) begin
         sing_cnt_d = 16'd0;
      end else if (out_valid_q && out_ready && out_sing_q &&
                   (sing_cnt_q != 16'hFFFF)) begin
         sing_cnt_d = sing_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sing_cnt_q <= 16'd0;
      end else begin
         sing_cnt_q <= sing_cnt_d;
      end
   end

   assign sing_cnt = sing_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_b_pipe
// Purpose  : Self-checking bench for d_b_pipe. Expected results come from a
//            table-and-arithmetic model of d_b or from hand-derived constants.
// Revision : 1.0  initial release
// ============================================================================

module tb_d_b_pipe;

   localparam int PIPE_MUL = 1;
   localparam int TAG_W    = 4;
   localparam int LAT      = (PIPE_MUL != 0) ? 3 : 2;
   localparam int BUDGET   = 2000;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [10:0]      in_z;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [10:0]      out_db;
   logic             out_sing;
   logic [TAG_W-1:0] out_tag;
`ifdef LNS_DB_SING_CNT_EN
   logic [15:0]      sing_cnt;
   logic             sing_cnt_clr;
`endif

   d_b_pipe #(.PIPE_MUL(PIPE_MUL), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_z       (in_z),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_db     (out_db),
      .out_sing   (out_sing),
      .out_tag    (out_tag)
`ifdef LNS_DB_SING_CNT_EN
      ,
      .sing_cnt     (sing_cnt),
      .sing_cnt_clr (sing_cnt_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0]      db;
      logic             sing;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             exp_q[$];
   int               stim_z[$];
   int               stim_db[$];
   bit               stim_sing[$];
   logic [TAG_W-1:0] tag_ctr;
   int               errors;
   int               checks;

   // Reference: pick the segment whose lower bound is the largest one not
   // above z, interpolate with integer floor division, then clamp.
   function automatic void ref_db(input int z, output int db, output bit sing);
      int zlo[7];
      int ylo[7];
      int kk[7];
      int s, p, q, r;
      zlo = '{-1024, -512, -256, -128, -64, -32, -16};
      ylo = '{-1, -12, -53, -128, -227, -339, -460};
      kk  = '{-5, -41, -150, -396, -896, -1936, -8602};
      if (z >= 0) begin
         db   = -1024;
         sing = 1'b1;
         return;
      end
      sing = 1'b0;
      s    = 0;
      for (int i = 0; i < 7; i++) if (z >= zlo[i]) s = i;
      p = (z - zlo[s]) * kk[s];
      q = p / 256;
      if ((p % 256) != 0 && p < 0) q = q - 1;
      r = ylo[s] + q;
      if (r < -1024) r = -1024;
      if (r > 0) r = 0;
      db = r;
   endfunction

   task automatic add_exp(input int z, input int db, input bit sing);
      stim_z.push_back(z);
      stim_db.push_back(db);
      stim_sing.push_back(sing);
   endtask

   task automatic add_model(input int z);
      int db;
      bit s;
      ref_db(z, db, s);
      add_exp(z, db, s);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   // Drives the stim queues through the DUT and scoreboards every transfer.
   // rmode: 0 = out_ready held 1, 1 = out_ready low for cycles [st_lo,st_hi),
   // 2 = random out_ready. vrand inserts random input bubbles.
   task automatic run_stream(input int rmode, input int st_lo, input int st_hi,
                             input bit vrand);
      int               sent, cyc, n, z, db;
      bit               pend, stall_prev;
      logic [10:0]      p_db;
      logic             p_sing;
      logic [TAG_W-1:0] p_tag;
      exp_t             e, got;
      sent = 0; cyc = 0; pend = 0; stall_prev = 0;
      p_db = '0; p_sing = 1'b0; p_tag = '0;
      n = stim_z.size();
      while ((sent < n || exp_q.size() != 0) && cyc < BUDGET) begin
         @(negedge clk);
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(cyc >= st_lo && cyc < st_hi);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (!pend) begin
            if (sent < n && (!vrand || $urandom_range(0, 4) != 0)) begin
               in_valid = 1'b1;
               z        = stim_z[sent];
               in_z     = z[10:0];
               in_tag   = tag_ctr;
            end else begin
               in_valid = 1'b0;
            end
         end
         #1;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, in_ready,
                     (!out_valid || out_ready));
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_db !== p_db || out_sing !== p_sing ||
                out_tag !== p_tag) begin
               errors++;
               $display("FAIL hold cyc=%0d: got v=%b db=%0d s=%b t=%0d expected v=1 db=%0d s=%b t=%0d",
                        cyc, out_valid, $signed(out_db), out_sing, out_tag,
                        $signed(p_db), p_sing, p_tag);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious cyc=%0d: got db=%0d t=%0d expected no output",
                        cyc, $signed(out_db), out_tag);
            end else begin
               e   = exp_q.pop_front();
               got = {out_db, out_sing, out_tag};
               if (got !== e) begin
                  errors++;
                  $display("FAIL result cyc=%0d: got db=%0d sing=%b tag=%0d expected db=%0d sing=%b tag=%0d",
                           cyc, $signed(got.db), got.sing, got.tag,
                           $signed(e.db), e.sing, e.tag);
               end
            end
         end
         stall_prev = (out_valid === 1'b1) && !out_ready;
         p_db = out_db; p_sing = out_sing; p_tag = out_tag;
         if (in_valid && in_ready) begin
            db     = stim_db[sent];
            e.db   = db[10:0];
            e.sing = stim_sing[sent];
            e.tag  = tag_ctr;
            exp_q.push_back(e);
            sent++;
            tag_ctr++;
            pend = 1'b0;
         end else begin
            pend = in_valid;
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= BUDGET) begin
         checks++;
         errors++;
         $display("FAIL timeout: got sent=%0d pending=%0d expected sent=%0d pending=0",
                  sent, exp_q.size(), n);
         exp_q.delete();
      end
      stim_z.delete();
      stim_db.delete();
      stim_sing.delete();
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (out_valid !== 1'b0 || out_db !== 11'd0 || out_sing !== 1'b0 ||
          out_tag !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b db=%0d s=%b t=%0d expected all 0",
                  out_valid, out_db, out_sing, out_tag);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", in_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_single();
      logic [10:0] exp_db;
      exp_db = 11'h7F4;  // -12
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_z      = 11'h600;  // -512
      in_tag    = 4'hA;
      for (int c = 1; c <= LAT + 1; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         checks++;
         if (out_valid !== (c == LAT)) begin
            errors++;
            $display("FAIL latency c=%0d: got out_valid=%b expected %b", c,
                     out_valid, (c == LAT));
         end
         if (c == LAT) begin
            checks++;
            if (out_db !== exp_db || out_sing !== 1'b0 || out_tag !== 4'hA) begin
               errors++;
               $display("FAIL single: got db=%0d s=%b t=%0d expected db=-12 s=0 t=10",
                        $signed(out_db), out_sing, out_tag);
            end
         end
      end
   endtask

   task automatic test_directed();
      add_exp(-1024, -1, 0);
      add_exp(-512, -12, 0);
      add_exp(-256, -53, 0);
      add_exp(-128, -128, 0);
      add_exp(-1, -965, 0);
      add_exp(-768, -6, 0);
      add_exp(-100, -172, 0);
      add_exp(-24, -400, 0);
      add_exp(0, -1024, 1);
      add_exp(37, -1024, 1);
      add_exp(1023, -1024, 1);
      add_model(-513);
      add_model(-17);
      add_model(-16);
      run_stream(0, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) add_model(int'($urandom_range(0, 1023)) - 1024);
      run_stream(1, 4, 9, 1'b0);
   endtask

   task automatic test_random();
      int z;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 0) z = int'($urandom_range(0, 2047)) - 1024;
         else                            z = -int'($urandom_range(0, 40));
         add_model(z);
      end
      run_stream(2, 0, 0, 1'b1);
   endtask

   task automatic test_reset_mid();
      int  zl[3];
      int  z;
      bit  seen;
      zl = '{-100, -24, -1};
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         in_valid = 1'b1;
         z        = zl[i];
         in_z     = z[10:0];
         in_tag   = TAG_W'(i + 1);
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL inflight: got out_valid=%b expected 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_db !== 11'd0 || out_tag !== '0) begin
         errors++;
         $display("FAIL async_reset: got v=%b db=%0d t=%0d expected all 0",
                  out_valid, $signed(out_db), out_tag);
      end
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL post_reset_emit: got out_valid=1 expected 0");
      end
      exp_q.delete();
   endtask

`ifdef LNS_DB_SING_CNT_EN
   task automatic test_sing_cnt();
      do_reset();
      for (int i = 0; i < 3; i++) add_exp(0, -1024, 1);
      run_stream(0, 0, 0, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (sing_cnt !== 16'd3) begin
         errors++;
         $display("FAIL sing_cnt: got %0d expected 3", sing_cnt);
      end
      sing_cnt_clr = 1'b1;
      @(negedge clk);
      sing_cnt_clr = 1'b0;
      #1;
      checks++;
      if (sing_cnt !== 16'd0) begin
         errors++;
         $display("FAIL sing_cnt_clr: got %0d expected 0", sing_cnt);
      end
   endtask
`endif

   initial begin
      errors    = 0;
      checks    = 0;
      tag_ctr   = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_z      = '0;
      in_tag    = '0;
      out_ready = 1'b0;
`ifdef LNS_DB_SING_CNT_EN
      sing_cnt_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef LNS_DB_SING_CNT_EN
      test_sing_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
